// File: rtl/vga_pattern_pkg.sv
// Shared types and constants for the VGA test-pattern source: mode codes,
// tracker FSM states, the tracker-to-colour payload and the RGB565 palette.
package vga_pattern_pkg;

  localparam int unsigned IDX_W = 3;

  localparam logic [1:0] MODE_HBAND = 2'd0;
  localparam logic [1:0] MODE_VBAR  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  localparam logic [0:0] ST_UNSYNC = 1'b0;
  localparam logic [0:0] ST_SYNC   = 1'b1;

  localparam logic [IDX_W-1:0] IDX_CHECK_EVEN = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_CHECK_ODD  = IDX_W'(7);

  // Everything the colour stage needs about the current pixel
  typedef struct packed {
    logic [1:0]       mode;
    logic [IDX_W-1:0] scroll;
    logic [IDX_W-1:0] band;
    logic [IDX_W-1:0] bar;
    logic             active;
  } pattern_ctx_t;

  function automatic logic [15:0] palette(input logic [IDX_W-1:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hF800;
      3'd1:    c = 16'h07E0;
      3'd2:    c = 16'h001F;
      3'd3:    c = 16'hFFFF;
      3'd4:    c = 16'hFFE0;
      3'd5:    c = 16'h07FF;
      3'd6:    c = 16'hF81F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Link between the pattern source (master) and vgadisplay (slave).
interface vga_pattern_gen_if #(
  parameter int unsigned ADDR_W = 24
);
  logic [ADDR_W-1:0] addr;
  logic              pix_clk;
  logic [15:0]       rgb;
  logic              frame_tick;
  logic              synced;

  modport master (input addr, output pix_clk, output rgb, output frame_tick, output synced);
  modport slave  (output addr, input pix_clk, input rgb, input frame_tick, input synced);
endinterface

// File: rtl/pixel_tracker.sv
// Follows vgadisplay's linear address incrementally and keeps x/y and band/bar
// indices; per-frame palette scroll exists only with PATTERN_SCROLL_EN.
module pixel_tracker
  import vga_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned NUM_BANDS = 3,
  parameter int unsigned ADDR_W    = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  output pattern_ctx_t      ctx,
  output logic              frame_tick,
  output logic              synced
);

  localparam int unsigned PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int unsigned BAND_H    = V_ACTIVE / NUM_BANDS;
  localparam int unsigned BAR_W     = H_ACTIVE / NUM_BANDS;
  localparam int unsigned X_W       = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W       = $clog2(V_ACTIVE + 1);
  localparam int unsigned BC_W      = $clog2(BAND_H + 1);
  localparam int unsigned XC_W      = $clog2(BAR_W + 1);

  logic [0:0]        state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic              active;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [XC_W-1:0]   bar_cnt;
  logic [BC_W-1:0]   band_cnt;
  logic [IDX_W-1:0]  bar, band, scroll;
  logic [1:0]        mode_q;
  logic              event_c, zero_c, seq_c, in_range_c, start_c, adv_c;

  assign event_c    = (addr != addr_q);
  assign zero_c     = (addr == '0);
  assign seq_c      = (addr == addr_q + ADDR_W'(1));
  assign in_range_c = (addr < ADDR_W'(PIX_TOTAL));

  // Next state and counter strobes
  always_comb begin
    state_n = state;
    start_c = 1'b0;
    adv_c   = 1'b0;
    if (event_c) begin
      case (state)
        ST_UNSYNC: begin
          if (zero_c) begin
            start_c = 1'b1;
            state_n = ST_SYNC;
          end
        end
        default: begin
          if (zero_c)          start_c = 1'b1;
          else if (!in_range_c) adv_c  = 1'b0;
          else if (seq_c)       adv_c  = 1'b1;
          else                  state_n = ST_UNSYNC;
        end
      endcase
    end
  end

  // addr_q resets to all-ones so an address of 0 right after reset still counts as an event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_UNSYNC;
      addr_q     <= '1;
      frame_tick <= 1'b0;
      synced     <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_n;
      addr_q     <= addr;
      frame_tick <= start_c;
      synced     <= (state_n == ST_SYNC);
      active     <= in_range_c;
    end
  end

  // Position and band/bar sub-counters; indices saturate on the remainder
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0; y <= '0; bar_cnt <= '0; band_cnt <= '0;
      bar <= '0; band <= '0; mode_q <= MODE_HBAND;
    end else if (start_c) begin
      x <= '0; y <= '0; bar_cnt <= '0; band_cnt <= '0;
      bar <= '0; band <= '0; mode_q <= mode;
    end else if (adv_c) begin
      if (x == X_W'(H_ACTIVE - 1)) begin
        x       <= '0;
        bar_cnt <= '0;
        bar     <= '0;
        if (y != Y_W'(V_ACTIVE - 1)) begin
          y <= y + Y_W'(1);
          if (band_cnt == BC_W'(BAND_H - 1)) begin
            band_cnt <= '0;
            if (band != IDX_W'(NUM_BANDS - 1)) band <= band + IDX_W'(1);
          end else begin
            band_cnt <= band_cnt + BC_W'(1);
          end
        end
      end else begin
        x <= x + X_W'(1);
        if (bar_cnt == XC_W'(BAR_W - 1)) begin
          bar_cnt <= '0;
          if (bar != IDX_W'(NUM_BANDS - 1)) bar <= bar + IDX_W'(1);
        end else begin
          bar_cnt <= bar_cnt + XC_W'(1);
        end
      end
    end
  end

`ifdef PATTERN_SCROLL_EN
  // Advances only on frame starts seen while locked
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                            scroll <= '0;
    else if (start_c && state == ST_SYNC)  scroll <= scroll + IDX_W'(1);
  end
`else
  assign scroll = '0;
`endif

  assign ctx = '{mode: mode_q, scroll: scroll, band: band, bar: bar, active: active};

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA test-pattern source: pixel-clock divider, pattern colour mux
// and registered RGB565 output. Optional palette scrolling: PATTERN_SCROLL_EN.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned NUM_BANDS = 3,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned ADDR_W    = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [IDX_W-1:0]   solid_idx,
  vga_pattern_gen_if.master  vga
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = $clog2(HALF + 1);

  pattern_ctx_t     ctx;
  logic             frame_tick, synced;
  logic [DIV_W-1:0] div_cnt;
  logic             pix_clk_q;
  logic [15:0]      rgb_q;
  logic [IDX_W-1:0] idx_c;

  pixel_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .NUM_BANDS(NUM_BANDS),
    .ADDR_W   (ADDR_W)
  ) u_tracker (
    .clock     (clock),
    .reset     (reset),
    .addr      (vga.addr),
    .mode      (mode),
    .ctx       (ctx),
    .frame_tick(frame_tick),
    .synced    (synced)
  );

  // Pixel clock: toggle every CLK_DIV/2 board clocks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      pix_clk_q <= 1'b0;
    end else if (div_cnt == DIV_W'(HALF - 1)) begin
      div_cnt   <= '0;
      pix_clk_q <= ~pix_clk_q;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    idx_c = '0;
    case (ctx.mode)
      MODE_HBAND: idx_c = ctx.band + ctx.scroll;
      MODE_VBAR:  idx_c = ctx.bar + ctx.scroll;
      MODE_CHECK: idx_c = ((ctx.band[0] ^ ctx.bar[0]) ? IDX_CHECK_ODD : IDX_CHECK_EVEN) + ctx.scroll;
      default:    idx_c = solid_idx;
    endcase
  end

  // Black while unlocked or outside the visible area
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rgb_q <= 16'h0000;
    else        rgb_q <= (synced && ctx.active) ? palette(idx_c) : 16'h0000;
  end

  assign vga.pix_clk    = pix_clk_q;
  assign vga.rgb        = rgb_q;
  assign vga.frame_tick = frame_tick;
  assign vga.synced     = synced;

endmodule
